// File: rtl/alu_arb_pkg.sv
// Shared definitions for the ALU arbiter: ALU op codes and FSM state encoding.
package alu_arb_pkg;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_SLT = 4'b0101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational ALU shared by both requesters. Unknown op codes fall back to ADD;
// SLT and the lt/gt flags compare the operands as unsigned values.
module alu_arbiter_alu
    import alu_arb_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OP_W   = 4
) (
    input  logic [OP_W-1:0]   i_op,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [DATA_W-1:0] o_result,
    output logic              o_zero,
    output logic              o_lt,
    output logic              o_gt
);

    // Operation select plus operand comparison flags.
    always_comb begin
        o_result = i_a + i_b;
        case (i_op)
            OP_SUB:  o_result = i_a - i_b;
            OP_AND:  o_result = i_a & i_b;
            OP_OR:   o_result = i_a | i_b;
            OP_XOR:  o_result = i_a ^ i_b;
            OP_SLT:  o_result = {{(DATA_W-1){1'b0}}, (i_a < i_b)};
            default: o_result = i_a + i_b;
        endcase
        o_zero = (o_result == '0);
        o_lt   = (i_a < i_b);
        o_gt   = (i_a > i_b);
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester front end for a single ALU. One transaction in flight at a time:
// IDLE (combinational grant) -> EXEC (ALU on latched operands) -> RESP (hold until taken).
// Build option: define ALU_ARB_RR_EN for round-robin tie breaking; otherwise
// requester 0 always wins a tie and no priority pointer exists.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OP_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [OP_W-1:0]   req0_op,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [OP_W-1:0]   req1_op,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_id,
    output logic [DATA_W-1:0] resp_result,
    output logic              resp_zero,
    output logic              resp_lt,
    output logic              resp_gt
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_grant0;
    logic                w_grant1;
    logic                w_take;

    logic [OP_W-1:0]     r_op;
    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_b;
    logic                r_id;

    logic [DATA_W-1:0]   w_alu_result;
    logic                w_alu_zero;
    logic                w_alu_lt;
    logic                w_alu_gt;

    logic [DATA_W-1:0]   r_resp_result;
    logic                r_resp_zero;
    logic                r_resp_lt;
    logic                r_resp_gt;
    logic                r_resp_id;

`ifdef ALU_ARB_RR_EN
    // r_prio names the requester that wins the next tie.
    logic                r_prio;

    // Priority pointer: after a grant, the other requester wins the next tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prio <= 1'b0;
        end else if (w_take) begin
            r_prio <= w_grant0;
        end
    end
`endif

    // Grant is purely combinational and only offered in IDLE; reset suppresses it.
    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (r_state == ST_IDLE && !rst) begin
`ifdef ALU_ARB_RR_EN
            if (req0_valid && req1_valid) begin
                w_grant0 = ~r_prio;
                w_grant1 = r_prio;
            end else begin
                w_grant0 = req0_valid;
                w_grant1 = req1_valid;
            end
`else
            w_grant0 = req0_valid;
            w_grant1 = req1_valid && !req0_valid;
`endif
        end
        w_take = w_grant0 | w_grant1;
    end

    // Next-state logic for the single-transaction FSM.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_take)     w_state_nxt = ST_EXEC;
            ST_EXEC:                 w_state_nxt = ST_RESP;
            ST_RESP: if (resp_ready) w_state_nxt = ST_IDLE;
            default:                 w_state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Accept stage: capture the winner's operands and index; the loser is never sampled.
    always_ff @(posedge clk) begin
        if (w_take) begin
            r_op <= w_grant1 ? req1_op : req0_op;
            r_a  <= w_grant1 ? req1_a  : req0_a;
            r_b  <= w_grant1 ? req1_b  : req0_b;
            r_id <= w_grant1;
        end
    end

    alu_arbiter_alu #(
        .DATA_W (DATA_W),
        .OP_W   (OP_W)
    ) u_alu (
        .i_op     (r_op),
        .i_a      (r_a),
        .i_b      (r_b),
        .o_result (w_alu_result),
        .o_zero   (w_alu_zero),
        .o_lt     (w_alu_lt),
        .o_gt     (w_alu_gt)
    );

    // Execute stage: register ALU result and flags; they hold until the next EXEC.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_resp_result <= '0;
            r_resp_zero   <= 1'b0;
            r_resp_lt     <= 1'b0;
            r_resp_gt     <= 1'b0;
            r_resp_id     <= 1'b0;
        end else if (r_state == ST_EXEC) begin
            r_resp_result <= w_alu_result;
            r_resp_zero   <= w_alu_zero;
            r_resp_lt     <= w_alu_lt;
            r_resp_gt     <= w_alu_gt;
            r_resp_id     <= r_id;
        end
    end

    assign req0_ready  = w_grant0;
    assign req1_ready  = w_grant1;
    assign resp_valid  = (r_state == ST_RESP);
    assign resp_id     = r_resp_id;
    assign resp_result = r_resp_result;
    assign resp_zero   = r_resp_zero;
    assign resp_lt     = r_resp_lt;
    assign resp_gt     = r_resp_gt;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: grants push reference results, responses pop and compare.
module tb_alu_arbiter;

    localparam int DATA_W = 32;
    localparam int OP_W   = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              req0_valid, req1_valid;
    logic              req0_ready, req1_ready;
    logic [OP_W-1:0]   req0_op, req1_op;
    logic [DATA_W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic              resp_valid, resp_ready, resp_id;
    logic [DATA_W-1:0] resp_result;
    logic              resp_zero, resp_lt, resp_gt;

    typedef struct packed {
        logic              id;
        logic [DATA_W-1:0] res;
        logic              z;
        logic              lt;
        logic              gt;
    } exp_t;

    exp_t sb[$];
    int   gnt_log[$];
    int   checks   = 0;
    int   failures = 0;

    alu_arbiter #(.DATA_W(DATA_W), .OP_W(OP_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_op     (req0_op),
        .req0_a      (req0_a),
        .req0_b      (req0_b),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_op     (req1_op),
        .req1_a      (req1_a),
        .req1_b      (req1_b),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_id     (resp_id),
        .resp_result (resp_result),
        .resp_zero   (resp_zero),
        .resp_lt     (resp_lt),
        .resp_gt     (resp_gt)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic id, input logic [3:0] op,
                                   input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        exp_t e;
        e.id = id;
        case (op)
            4'h1:    e.res = a - b;
            4'h2:    e.res = a & b;
            4'h3:    e.res = a | b;
            4'h4:    e.res = a ^ b;
            4'h5:    e.res = (a < b) ? 32'd1 : 32'd0;
            default: e.res = a + b;
        endcase
        e.z  = (e.res == 32'd0);
        e.lt = (a < b);
        e.gt = (a > b);
        return e;
    endfunction

    // Monitor: grants push expectations, handshaken responses pop and compare.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            sb.delete();
        end else begin
            if (req0_ready || req1_ready) begin
                check_val("one_ready", {63'd0, req0_ready & req1_ready}, 64'd0);
                check_val("ready_needs_valid",
                          {63'd0, (req0_ready & ~req0_valid) | (req1_ready & ~req1_valid)}, 64'd0);
            end
            if (req0_ready && req0_valid) begin
                sb.push_back(model(1'b0, req0_op, req0_a, req0_b));
                gnt_log.push_back(0);
            end else if (req1_ready && req1_valid) begin
                sb.push_back(model(1'b1, req1_op, req1_a, req1_b));
                gnt_log.push_back(1);
            end
            if (resp_valid && resp_ready) begin
                if (sb.size() == 0) begin
                    check_val("spurious_resp", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check_val("resp_id",     {63'd0, resp_id},    {63'd0, e.id});
                    check_val("resp_result", {32'd0, resp_result}, {32'd0, e.res});
                    check_val("resp_zero",   {63'd0, resp_zero},  {63'd0, e.z});
                    check_val("resp_lt",     {63'd0, resp_lt},    {63'd0, e.lt});
                    check_val("resp_gt",     {63'd0, resp_gt},    {63'd0, e.gt});
                end
            end
        end
    end

    task automatic send(input int who, input logic [3:0] op,
                        input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        bit ok = 0;
        @(posedge clk); #1;
        if (who == 0) begin
            req0_op = op; req0_a = a; req0_b = b; req0_valid = 1'b1;
        end else begin
            req1_op = op; req1_a = a; req1_b = b; req1_valid = 1'b1;
        end
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if ((who == 0 && req0_ready) || (who == 1 && req1_ready)) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check_val("grant_timeout", 64'd1, 64'd0);
        @(posedge clk); #1;
        if (who == 0) req0_valid = 1'b0;
        else          req1_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !resp_valid) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check_val("idle_timeout", 64'd1, 64'd0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        exp_t e;
        bit   ok;
        rst = 1'b1;
        req0_valid = 0; req1_valid = 0; resp_ready = 1'b1;
        req0_op = '0; req0_a = '0; req0_b = '0;
        req1_op = '0; req1_a = '0; req1_b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_valid",  {63'd0, resp_valid},  64'd0);
        check_val("rst_result", {32'd0, resp_result}, 64'd0);
        check_val("rst_flags",  {61'd0, resp_zero, resp_lt, resp_gt}, 64'd0);
        check_val("rst_id",     {63'd0, resp_id},     64'd0);
        check_val("rst_ready",  {62'd0, req0_ready, req1_ready}, 64'd0);
        @(posedge clk); #1 rst = 1'b0;

        // Req0 ADD 5+7: grant visible, response two edges later, valid for one cycle.
        @(posedge clk); #1;
        req0_op = 4'h0; req0_a = 32'd5; req0_b = 32'd7; req0_valid = 1'b1;
        @(negedge clk);
        check_val("t1_rdy0", {63'd0, req0_ready}, 64'd1);
        check_val("t1_rdy1", {63'd0, req1_ready}, 64'd0);
        @(posedge clk); #1 req0_valid = 1'b0;
        @(negedge clk);
        check_val("t1_exec_vld", {63'd0, resp_valid}, 64'd0);
        @(negedge clk);
        check_val("t1_resp_vld", {63'd0, resp_valid}, 64'd1);
        @(negedge clk);
        check_val("t1_one_cycle", {63'd0, resp_valid}, 64'd0);
        wait_idle();

        // Req1 SUB 9-9 -> zero, and undefined op 4'hF -> ADD.
        send(1, 4'h1, 32'd9, 32'd9);
        wait_idle();
        send(0, 4'hF, 32'd3, 32'd4);
        wait_idle();
        for (int op = 2; op <= 5; op++) begin
            send(op % 2, op[3:0], $urandom, $urandom);
            wait_idle();
        end
        send(1, 4'h5, 32'hFFFF_FFFF, 32'd1);
        wait_idle();
        send(0, 4'h1, 32'd0, 32'd1);
        wait_idle();

        // Both requesters valid continuously from a fresh reset.
        do_reset();
        gnt_log.delete();
        @(posedge clk); #1;
        req0_op = 4'h0; req0_a = 32'd1; req0_b = 32'd1; req0_valid = 1'b1;
        req1_op = 4'h1; req1_a = 32'd50; req1_b = 32'd8; req1_valid = 1'b1;
        ok = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (gnt_log.size() >= 4) begin
                ok = 1;
                break;
            end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        if (!ok) begin
            check_val("arb_timeout", 64'd1, 64'd0);
        end else begin
            for (int i = 0; i < 4; i++) begin
`ifdef ALU_ARB_RR_EN
                check_val($sformatf("arb_gnt%0d", i), 64'(gnt_log[i]), 64'(i % 2));
`else
                check_val($sformatf("arb_gnt%0d", i), 64'(gnt_log[i]), 64'd0);
`endif
            end
        end
        wait_idle();

        // Consumer stalls 5 cycles in RESP while req1 waits; then release.
        resp_ready = 1'b0;
        e = model(1'b0, 4'h4, 32'hF0F0_1234, 32'h0FF0_4321);
        send(0, 4'h4, 32'hF0F0_1234, 32'h0FF0_4321);
        req1_op = 4'h0; req1_a = 32'd10; req1_b = 32'd20; req1_valid = 1'b1;
        ok = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (resp_valid) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check_val("hold_resp_timeout", 64'd1, 64'd0);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            check_val("hold_valid",  {63'd0, resp_valid},  64'd1);
            check_val("hold_result", {32'd0, resp_result}, {32'd0, e.res});
            check_val("hold_ready",  {62'd0, req0_ready, req1_ready}, 64'd0);
        end
        @(posedge clk); #1 resp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_val("release_idle_vld", {63'd0, resp_valid}, 64'd0);
        check_val("release_rdy1",     {63'd0, req1_ready}, 64'd1);
        @(posedge clk); #1 req1_valid = 1'b0;
        wait_idle();

        // Reset while req0 SLT 1<2 is in EXEC: transaction discarded.
        @(posedge clk); #1;
        req0_op = 4'h5; req0_a = 32'd1; req0_b = 32'd2; req0_valid = 1'b1;
        @(negedge clk);
        check_val("rstx_grant", {63'd0, req0_ready}, 64'd1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_val("rstx_valid", {63'd0, resp_valid}, 64'd0);
        end
        check_val("rstx_result", {32'd0, resp_result}, 64'd0);
        check_val("rstx_flags",  {61'd0, resp_zero, resp_lt, resp_gt}, 64'd0);
        check_val("rstx_id",     {63'd0, resp_id}, 64'd0);
        send(0, 4'h5, 32'd1, 32'd2);
        wait_idle();

        // Random mixed traffic.
        for (int i = 0; i < 8; i++) begin
            send(int'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom, $urandom);
            wait_idle();
        end

        check_val("sb_empty", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
